// File: rtl/arb_pkg.sv
// Shared types and a reference rotating-priority pick for the
// round-robin arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  localparam int unsigned RR_MAX_N  = 64;
  localparam int unsigned RR_MAX_IW = 6;

  typedef struct packed {
    logic                 found;
    logic [RR_MAX_IW-1:0] idx;
  } rr_pick_t;

  // Rotate req so ptr lands at bit 0, then take the lowest set bit.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX_N-1:0] req,
    input int unsigned         n,
    input int unsigned         ptr
  );
    rr_pick_t             r;
    logic [RR_MAX_N-1:0]  rot;
    int unsigned          j;
    r   = '0;
    rot = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n) rot[k] = req[j[RR_MAX_IW-1:0]];
    end
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (!r.found && rot[k]) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        r.found = 1'b1;
        r.idx   = j[RR_MAX_IW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational rotating-priority select: first set req bit at or
// after ptr, wrapping modulo N.
module arb_rr_select
  import arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Upper copy supplies the wrapped candidates below ptr.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 2*N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = (i >= N) ? IW'(i - N) : IW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Registered round-robin arbiter with grant hold and MAX_HOLD
// forced rotation.
module rr_arbiter_fsm
  import arb_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          preempt
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          preempt_q, preempt_d;

  logic [IW-1:0] nxt_ptr;
  logic [IW-1:0] sel_ptr;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic          own_req;
  logic          timeout;

  assign own_req = req[idx_q];
  assign nxt_ptr = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
  assign timeout = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));

  // A busy owner only hands over on release or timeout, both of
  // which restart the search just past the owner.
  assign sel_ptr = (state_q == BUSY) ? nxt_ptr : ptr_q;

  arb_rr_select #(
    .N  (N),
    .IW (IW)
  ) u_sel (
    .req   (req),
    .ptr   (sel_ptr),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          gnt_d   = N'(1) << sel_idx;
          idx_d   = sel_idx;
          valid_d = 1'b1;
          hold_d  = HW'(1);
        end
      end
      BUSY: begin
        if (own_req && !timeout) begin
          if (hold_q != '1) hold_d = hold_q + HW'(1);
        end else begin
          ptr_d = nxt_ptr;
          if (sel_found) begin
            gnt_d     = N'(1) << sel_idx;
            idx_d     = sel_idx;
            valid_d   = 1'b1;
            hold_d    = HW'(1);
            preempt_d = own_req;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Scoreboard bench for rr_arbiter_fsm (N=8, MAX_HOLD=4).
module tb_rr_arbiter_fsm;

  localparam int N  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         gnt_valid;
  logic         preempt;

  always #5 clk = ~clk;

  rr_arbiter_fsm #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [2:0]   idx;
    logic         valid;
    logic         pre;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_last  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic int scan(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (from + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic exp_t model_step(input logic [N-1:0] r);
    exp_t e;
    logic pre;
    pre = 1'b0;
    if (m_owner < 0) begin
      m_owner = scan(r, m_ptr);
      m_hold  = 1;
    end else if (r[m_owner] && m_hold < MH) begin
      m_hold++;
    end else begin
      pre     = r[m_owner];
      m_ptr   = (m_owner + 1) % N;
      m_owner = scan(r, m_ptr);
      m_hold  = 1;
      if (m_owner < 0) pre = 1'b0;
    end
    if (m_owner >= 0) m_last = m_owner;
    e.gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.idx   = m_last[2:0];
    e.valid = (m_owner >= 0);
    e.pre   = pre;
    return e;
  endfunction

  task automatic cyc(input logic [N-1:0] r, input logic rst = 1'b1);
    @(negedge clk);
    req   = r;
    rst_n = rst;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_last  = 0;
      q.push_back(exp_t'(0));
    end else begin
      q.push_back(model_step(r));
    end
  endtask

  initial begin
    forever begin : mon
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("gnt_idx", gnt_idx, e.idx);
        chk("gnt_valid", gnt_valid, e.valid);
        chk("preempt", preempt, e.pre);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic         rb;

    repeat (3) cyc(8'hFF, 1'b0);

    repeat (3) cyc(8'h08);
    repeat (3) cyc(8'h00);
    cyc(8'h18);
    cyc(8'h00);

    cyc(8'h00, 1'b0);
    cyc(8'hB0);
    cyc(8'hA0);
    cyc(8'h90);
    cyc(8'h10);
    cyc(8'h00);

    cyc(8'h00, 1'b0);
    repeat (36) cyc(8'hFF);

    cyc(8'h00, 1'b0);
    repeat (10) cyc(8'h04);
    cyc(8'h00);

    cyc(8'h00, 1'b0);
    repeat (3) cyc(8'h40);
    @(posedge clk);
    #2;
    chk("pre_async_gnt", gnt, 8'h40);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_valid", gnt_valid, 0);
    chk("async_preempt", preempt, 0);
    chk("async_idx", gnt_idx, 0);
    cyc(8'hFF, 1'b0);
    repeat (3) cyc(8'hFF);

    r = '0;
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: r = N'($urandom);
          1: r = N'(1) << $urandom_range(0, N - 1);
          2: r = N'($urandom) & N'($urandom);
          default: r = '0;
        endcase
      end
      rb = ($urandom_range(0, 99) != 0);
      cyc(r, rb);
    end

    cyc(8'h00);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_fsm.md
Name: rr_arbiter_fsm

Overview:
- Registered round-robin arbiter that shares one resource between N requesters.
- Selects one requester per grant with rotating priority and holds the grant while that requester keeps its request high.
- Forces rotation after MAX_HOLD cycles so no requester starves the others.
- Sits in front of the shared datapath; gnt_idx and gnt_valid drive the downstream decoder and enable.

Parameters:
- N, 8, number of requesters (≥2, any value; non-power-of-2 legal).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner. 0 disables forced rotation.
- IW, $clog2(N), index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, level-sensitive, one bit per requester.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IW  binary index of the owner; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse in the cycle a grant is replaced because of a MAX_HOLD timeout.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0. Reset takes effect immediately on assertion, including mid-grant.
- State: IDLE (no owner) and BUSY (owner held). ptr is the IW-bit search start. hold_cnt counts grant cycles.
- Selection: the first set bit of req scanning ptr, ptr+1, … N-1, 0, … ptr-1 (wrap modulo N).
- IDLE:
  - req≠0 → the selected requester is granted in the next cycle (1-cycle latency). gnt_valid=1, hold_cnt=1, go to BUSY.
  - req=0 → stay in IDLE.
- BUSY, owner's req=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD): hold the grant and increment hold_cnt. hold_cnt saturates when MAX_HOLD=0.
- BUSY, owner's req=0 (release):
  - ptr←owner+1 mod N.
  - If other requests exist, the next owner is granted in the next cycle with no idle bubble.
  - Otherwise gnt=0, gnt_valid=0, state=IDLE.
- BUSY, owner's req=1 and hold_cnt==MAX_HOLD (timeout):
  - ptr←owner+1 mod N and reselect.
  - If another requester exists, it is granted next cycle with preempt=1 for that cycle.
  - If the owner is the only requester, the owner is re-granted, hold_cnt←1, preempt=1.
- Result: an owner holds for at most MAX_HOLD consecutive cycles while others are waiting.
- Requests from non-owners are never latched; a request dropped before being selected is lost.
- Simultaneous release and new requests: resolved in the same evaluation; the new owner is chosen from the current req.
- Invariants: gnt is always one-hot or zero. gnt_idx is held at its last value when gnt_valid=0. gnt_valid is high exactly when gnt≠0.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_e;
  - function rr_pick(req, ptr), returning {found, idx}, implemented as a rotated-mask priority select.
- One natural sub-module: arb_rr_select, combinational. It takes req and ptr and returns found and idx using a double-width masked priority encode.
- The FSM, ptr, hold_cnt and output registers live in rr_arbiter_fsm.

Test Plan (N=8, MAX_HOLD=4):
- Reset: hold rst_n=0 with req=8'hFF → gnt=0, gnt_valid=0, gnt_idx=0, preempt=0 on every cycle.
- Single request: req=8'b0000_1000 at cycle 0 → cycle 1 gnt=8'b0000_1000, gnt_idx=3, gnt_valid=1. Drop req at cycle 3 (hold_cnt=3 < MAX_HOLD) → cycle 4 gnt=0, gnt_valid=0. Next search starts at 4.
- Rotation on release: with ptr=0, req=8'b1011_0000 → gnt bit 4. Release bit 4 → next cycle gnt bit 5, no gap. Release bit 5 → gnt bit 7. Release bit 7 → gnt bit 4, wrap.
- Timeout fairness: req=8'hFF held constant from reset → owners 0,1,2,…,7,0 each for exactly 4 cycles. preempt pulses on every handover, 0 elsewhere.
- Sole hog: req=8'b0000_0100 held 10 cycles → gnt stays bit 2 throughout. preempt=1 on cycles 5 and 9 after the first grant. gnt_valid never drops.
- Async reset mid-grant: assert rst_n=0 between clock edges while gnt=bit 6 → gnt, gnt_valid and preempt go to 0 immediately. After release, req=8'hFF → first grant is bit 0.
